// File: rtl/rq_former_multi.sv
// Purpose: per-channel strobe synchroniser + delayed fixed-length request pulse with overrun flag.
// Latency: RQ rises SYNC_STAGES+DELAY cycles after the edge that first samples val high.
// Backpressure: none; a held strobe never retriggers, early re-strobes only set ovr.
module rq_former_multi #(
    parameter int CHANNELS    = 4,
    parameter int DELAY_W     = 4,
    parameter int DELAY       = 8,
    parameter int PULSE_LEN   = 2,
    parameter int SYNC_STAGES = 2,
    parameter int ABORT_EN    = 0
) (
    input  logic                clk80MHz,
    input  logic                rst,
    input  logic [CHANNELS-1:0] val,
    input  logic [CHANNELS-1:0] clr_ovr,
    output logic [CHANNELS-1:0] RQ,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] ovr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CNT   = 2'd1;
    localparam logic [1:0] S_PULSE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // Last count values: the state is left when the counter reaches these.
    localparam logic [DELAY_W-1:0] DLY_LAST = DELAY_W'(DELAY - 1);
    localparam logic [2:0]         PLS_LAST = 3'(PULSE_LEN - 1);
    localparam bit                 ABORT    = (ABORT_EN != 0);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [SYNC_STAGES-1:0] sync_q;
        logic                   prev_q;
        logic [1:0]             state_q, state_d;
        logic [DELAY_W-1:0]     cnt_q, cnt_d;
        logic [2:0]             pcnt_q, pcnt_d;
        logic                   rq_q, rq_d;
        logic                   busy_q, busy_d;
        logic                   ovr_q, ovr_d;
        logic                   s_lvl, s_rise;

        assign s_lvl  = sync_q[SYNC_STAGES-1];
        assign s_rise = s_lvl & ~prev_q;

        // Synchroniser chain plus one flop of history for rising-edge detection.
        always_ff @(posedge clk80MHz or negedge rst) begin
            if (!rst) begin
                sync_q <= '0;
                prev_q <= 1'b0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], val[g]};
                prev_q <= s_lvl;
            end
        end

        // Next-state logic: IDLE -> CNT (delay) -> PULSE (request) -> WAIT (strobe low re-arms).
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            pcnt_d  = pcnt_q;
            rq_d    = 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (s_lvl) begin
                        state_d = S_CNT;
                        cnt_d   = '0;
                    end
                end
                S_CNT: begin
                    // Abort is checked first so it wins over delay expiry.
                    if (ABORT && !s_lvl) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == DLY_LAST) begin
                        state_d = S_PULSE;
                        pcnt_d  = '0;
                        rq_d    = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_PULSE: begin
                    if (pcnt_q == PLS_LAST) begin
                        state_d = S_WAIT;
                    end else begin
                        pcnt_d = pcnt_q + 1'b1;
                        rq_d   = 1'b1;
                    end
                end
                default: begin
                    if (!s_lvl) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
            busy_d = (state_d != S_IDLE);
            // A fresh edge while a request is still being formed is flagged, never re-issued.
            if (s_rise && (state_q == S_CNT || state_q == S_PULSE)) begin
                ovr_d = 1'b1;
            end else if (clr_ovr[g]) begin
                ovr_d = 1'b0;
            end else begin
                ovr_d = ovr_q;
            end
        end

        // Channel state and registered outputs.
        always_ff @(posedge clk80MHz or negedge rst) begin
            if (!rst) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pcnt_q  <= '0;
                rq_q    <= 1'b0;
                busy_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                pcnt_q  <= pcnt_d;
                rq_q    <= rq_d;
                busy_q  <= busy_d;
                ovr_q   <= ovr_d;
            end
        end

        assign RQ[g]   = rq_q;
        assign busy[g] = busy_q;
        assign ovr[g]  = ovr_q;
    end

endmodule

// File: tb/tb_rq_former_multi.sv
// Purpose: directed bench for rq_former_multi, default DUT plus an ABORT_EN=1 copy on shared inputs.
// Latency: stimulus tables index cycles from E0; logs are sampled 1 ns after each edge.
// Backpressure: not applicable; every run has a fixed cycle count.
module tb_rq_former_multi;

    logic       clk80MHz;
    logic       rst;
    logic [3:0] val;
    logic [3:0] clr_ovr;
    logic [3:0] RQ, busy, ovr;
    logic [3:0] RQ_a, busy_a, ovr_a;

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0] val_tab  [0:79];
    logic [3:0] clr_tab  [0:79];
    logic [3:0] rq_log   [0:79];
    logic [3:0] busy_log [0:79];
    logic [3:0] ovr_log  [0:79];
    logic [3:0] rqa_log  [0:79];
    logic [3:0] busya_log[0:79];

    rq_former_multi u_dut (
        .clk80MHz(clk80MHz), .rst(rst), .val(val), .clr_ovr(clr_ovr),
        .RQ(RQ), .busy(busy), .ovr(ovr)
    );

    rq_former_multi #(.ABORT_EN(1)) u_dut_abort (
        .clk80MHz(clk80MHz), .rst(rst), .val(val), .clr_ovr(clr_ovr),
        .RQ(RQ_a), .busy(busy_a), .ovr(ovr_a)
    );

    initial clk80MHz = 1'b0;
    always #5 clk80MHz = ~clk80MHz;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_tabs();
        for (int k = 0; k < 80; k++) begin
            val_tab[k] = 4'h0;
            clr_tab[k] = 4'h0;
        end
    endtask

    task automatic fill_val(input int ch, input int from, input int to);
        for (int k = from; k <= to; k++) val_tab[k][ch] = 1'b1;
    endtask

    // Apply table entry k before edge Ek, record outputs 1 ns after Ek.
    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            val     = val_tab[k];
            clr_ovr = clr_tab[k];
            @(posedge clk80MHz);
            #1;
            rq_log[k]    = RQ;
            busy_log[k]  = busy;
            ovr_log[k]   = ovr;
            rqa_log[k]   = RQ_a;
            busya_log[k] = busy_a;
        end
        val     = 4'h0;
        clr_ovr = 4'h0;
    endtask

    function automatic int cnt_rq(input int ch, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (rq_log[k][ch]) c++;
        return c;
    endfunction

    function automatic int cnt_rqa(input int ch, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (rqa_log[k][ch]) c++;
        return c;
    endfunction

    function automatic int cnt_busy(input int ch, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if (busy_log[k][ch]) c++;
        return c;
    endfunction

    function automatic int first_rise(input int ch, input int from, input int n);
        for (int k = from; k < n; k++)
            if (rq_log[k][ch] && (k == 0 || !rq_log[k-1][ch])) return k;
        return -1;
    endfunction

    function automatic int rise_cnt(input int ch, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (rq_log[k][ch] && (k == 0 || !rq_log[k-1][ch])) c++;
        return c;
    endfunction

    function automatic int any_rq(input logic [3:0] mask, input int n);
        int c = 0;
        for (int k = 0; k < n; k++) if ((rq_log[k] & mask) != 4'h0) c++;
        return c;
    endfunction

    initial begin
        rst     = 1'b0;
        val     = 4'h0;
        clr_ovr = 4'h0;
        #2;
        check("rst_rq",   int'(RQ),   0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr",  int'(ovr),  0);
        repeat (2) @(posedge clk80MHz);
        #1 rst = 1'b1;

        // Single channel, strobe held 20 cycles.
        clear_tabs();
        fill_val(0, 0, 19);
        run(30);
        check("t1_rq0_rise",   first_rise(0, 0, 30), 10);
        check("t1_rq0_len",    cnt_rq(0, 30), 2);
        check("t1_rq0_k11",    int'(rq_log[11][0]), 1);
        check("t1_rq0_k12",    int'(rq_log[12][0]), 0);
        check("t1_other_rq",   any_rq(4'hE, 30), 0);
        check("t1_busy_len",   cnt_busy(0, 30), 20);
        check("t1_busy_k2",    int'(busy_log[2][0]), 1);
        check("t1_busy_k21",   int'(busy_log[21][0]), 1);
        check("t1_busy_k22",   int'(busy_log[22][0]), 0);
        check("t1_busy_other", cnt_busy(1, 30) + cnt_busy(2, 30) + cnt_busy(3, 30), 0);

        // Held level gives one pulse; drop and re-raise gives a second.
        clear_tabs();
        fill_val(1, 0, 39);
        fill_val(1, 45, 64);
        run(70);
        check("t2_rises",       rise_cnt(1, 70), 2);
        check("t2_first",       first_rise(1, 0, 70), 10);
        check("t2_no_retrig",   cnt_rq(1, 45), 2);
        check("t2_second",      first_rise(1, 45, 70), 55);
        check("t2_total_len",   cnt_rq(1, 70), 4);

        // Short strobe: completes without abort, cancelled with abort.
        clear_tabs();
        fill_val(2, 0, 3);
        run(16);
        check("t3_noab_rise",   first_rise(2, 0, 16), 10);
        check("t3_noab_len",    cnt_rq(2, 16), 2);
        check("t3_ab_rq",       cnt_rqa(2, 16), 0);
        check("t3_ab_busy_k5",  int'(busya_log[5][2]), 1);
        check("t3_ab_busy_k6",  int'(busya_log[6][2]), 0);

        // Overrun during CNT, then set-vs-clear priority, then clear alone.
        clear_tabs();
        fill_val(3, 0, 2);
        fill_val(3, 5, 29);
        fill_val(3, 40, 42);
        fill_val(3, 45, 59);
        clr_tab[47][3] = 1'b1;
        clr_tab[52][3] = 1'b1;
        run(66);
        check("t4_ovr_k6",      int'(ovr_log[6][3]), 0);
        check("t4_ovr_k7",      int'(ovr_log[7][3]), 1);
        check("t4_single_rq",   cnt_rq(3, 40), 2);
        check("t4_rq_rise",     first_rise(3, 0, 40), 10);
        check("t4_ovr_k46",     int'(ovr_log[46][3]), 1);
        check("t4_set_wins",    int'(ovr_log[47][3]), 1);
        check("t4_ovr_k51",     int'(ovr_log[51][3]), 1);
        check("t4_clr",         int'(ovr_log[52][3]), 0);
        check("t4_rq_rise2",    first_rise(3, 40, 66), 50);
        check("t4_ovr_other",   int'(ovr_log[65][2:0]), 0);

        // All channels together, then asynchronous reset while RQ is high.
        clear_tabs();
        for (int c = 0; c < 4; c++) fill_val(c, 0, 15);
        run(11);
        val = 4'hF;
        check("t5_rq_k9",   int'(rq_log[9]), 0);
        check("t5_rq_k10",  int'(rq_log[10]), 15);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_rq",   int'(RQ), 0);
        check("t5_rst_busy", int'(busy), 0);
        check("t5_rst_ovr",  int'(ovr), 0);
        check("t5_rst_rqa",  int'(RQ_a), 0);
        val = 4'h0;
        repeat (2) @(posedge clk80MHz);
        #1 rst = 1'b1;
        clear_tabs();
        run(20);
        check("t5_no_replay",   any_rq(4'hF, 20), 0);
        check("t5_idle_busy",   int'(busy_log[19]), 0);
        clear_tabs();
        fill_val(0, 0, 14);
        run(25);
        check("t5_new_rise",    first_rise(0, 0, 25), 10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
